// File: rtl/knn_pkg.sv
// ============================================================================
// knn_pkg : shared types, widths and helpers for the k-NN pipeline blocks
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package knn_pkg;

  localparam int KNN_WIDE         = 48;
  localparam int KNN_DATA_WIDE    = 3;
  localparam int SAMPLE_W         = KNN_WIDE + KNN_DATA_WIDE;
  localparam int KNN_COM_NUM      = 600;
  localparam int KNN_ADDR_W       = 11;
  localparam int KNN_DRAIN_CYCLES = 8;
  localparam int CSUM_W           = 16;

  // Counter width able to hold the value n; never narrower than one bit.
  function automatic int knn_cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  localparam int DRAIN_W = knn_cnt_w(KNN_DRAIN_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } knn_state_e;

endpackage

`default_nettype wire

// File: rtl/knn_feeder_rdpipe.sv
// ============================================================================
// knn_feeder_rdpipe : aligns valid/sof/eof with the 1-cycle sample memory read
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module knn_feeder_rdpipe
  import knn_pkg::*;
#(
  parameter int SW = SAMPLE_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_flush,
  input  logic          i_valid,
  input  logic          i_sof,
  input  logic          i_eof,
  input  logic [SW-1:0] i_rdata,
  output logic [SW-1:0] o_data,
  output logic          o_valid,
  output logic          o_sof,
  output logic          o_eof
);

  logic r_valid;
  logic r_sof;
  logic r_eof;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_sof   <= 1'b0;
      r_eof   <= 1'b0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
      r_sof   <= 1'b0;
      r_eof   <= 1'b0;
    end else begin
      r_valid <= i_valid;
      r_sof   <= i_sof;
      r_eof   <= i_eof;
    end
  end

  // The memory's own output register is the data stage; gating keeps idle cycles at zero.
  assign o_data  = r_valid ? i_rdata : '0;
  assign o_valid = r_valid;
  assign o_sof   = r_sof;
  assign o_eof   = r_eof;

endmodule

`default_nettype wire

// File: rtl/knn_sample_feeder.sv
// ============================================================================
// knn_sample_feeder : latches a query and streams COM_NUM training samples
// Optional: KNN_FEEDER_CHECKSUM_EN adds a running 16-bit sample checksum.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module knn_sample_feeder
  import knn_pkg::*;
#(
  parameter int WIDE         = KNN_WIDE,
  parameter int DATA_WIDE    = KNN_DATA_WIDE,
  parameter int COM_NUM      = KNN_COM_NUM,
  parameter int ADDR_W       = KNN_ADDR_W,
  parameter int DRAIN_CYCLES = KNN_DRAIN_CYCLES
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_start,
  input  logic                      i_abort,
  input  logic [WIDE-1:0]           i_query,
  output logic                      o_mem_en,
  output logic [ADDR_W-1:0]         o_mem_addr,
  input  logic [WIDE+DATA_WIDE-1:0] i_mem_rdata,
  output logic [WIDE-1:0]           o_feature,
  output logic [WIDE+DATA_WIDE-1:0] o_train_data,
  output logic                      o_sample_valid,
  output logic                      o_sof,
  output logic                      o_eof,
  output logic                      o_busy,
  output logic                      o_done
`ifdef KNN_FEEDER_CHECKSUM_EN
  ,
  output logic [CSUM_W-1:0]         o_csum
`endif
);

  localparam int SW = WIDE + DATA_WIDE;
  localparam int DW = knn_cnt_w(DRAIN_CYCLES);
  localparam logic [ADDR_W-1:0] c_last_addr  = ADDR_W'(COM_NUM - 1);
  localparam logic [DW-1:0]     c_drain_last = DW'(DRAIN_CYCLES);

  knn_state_e        r_state;
  logic              r_mem_en;
  logic [ADDR_W-1:0] r_addr;
  logic [DW-1:0]     r_drain_cnt;
  logic [WIDE-1:0]   r_feature;
  logic              r_busy;
  logic              r_done;

  logic              w_accept;
  logic              w_flush;
  logic              w_sof;
  logic              w_eof;
  logic [SW-1:0]     w_train_data;
  logic              w_valid;

  assign w_accept = (r_state == ST_IDLE) && i_start;
  assign w_flush  = (r_state != ST_IDLE) && i_abort;
  assign w_sof    = r_mem_en && (r_addr == '0);
  assign w_eof    = r_mem_en && (r_addr == c_last_addr);

  // Abort outranks every transition; in IDLE it is a no-op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_mem_en    <= 1'b0;
      r_addr      <= '0;
      r_drain_cnt <= '0;
      r_feature   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else if (w_flush) begin
      r_state     <= ST_IDLE;
      r_mem_en    <= 1'b0;
      r_addr      <= '0;
      r_drain_cnt <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_feature <= i_query;
            r_mem_en  <= 1'b1;
            r_addr    <= '0;
            r_busy    <= 1'b1;
            r_state   <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (r_addr == c_last_addr) begin
            r_mem_en    <= 1'b0;
            r_addr      <= '0;
            r_drain_cnt <= '0;
            r_state     <= ST_DRAIN;
          end else begin
            r_addr <= r_addr + 1'b1;
          end
        end
        // DRAIN is entered on the eof cycle, so DRAIN_CYCLES extra cycles follow it.
        ST_DRAIN: begin
          if (r_drain_cnt == c_drain_last) begin
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_drain_cnt <= r_drain_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  knn_feeder_rdpipe #(
    .SW (SW)
  ) u_rdpipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (w_flush),
    .i_valid (r_mem_en),
    .i_sof   (w_sof),
    .i_eof   (w_eof),
    .i_rdata (i_mem_rdata),
    .o_data  (w_train_data),
    .o_valid (w_valid),
    .o_sof   (o_sof),
    .o_eof   (o_eof)
  );

  assign o_mem_en       = r_mem_en;
  assign o_mem_addr     = r_addr;
  assign o_feature      = r_feature;
  assign o_train_data   = w_train_data;
  assign o_sample_valid = w_valid;
  assign o_busy         = r_busy;
  assign o_done         = r_done;

`ifdef KNN_FEEDER_CHECKSUM_EN
  logic [CSUM_W-1:0] r_csum;
  logic [CSUM_W-1:0] w_word;

  assign w_word = CSUM_W'(w_train_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_csum <= '0;
    end else if (w_accept) begin
      r_csum <= '0;
    end else if (w_valid) begin
      r_csum <= r_csum + w_word;
    end
  end

  assign o_csum = r_csum;
`endif

endmodule

`default_nettype wire
